// File: rtl/ped_signal_ctrl_if.sv
// Purpose : bundles the vehicle-light / push-button inputs and lamp outputs of ped_signal_ctrl.
// Latency : n/a (signal bundle only).
// Backpressure: none; the slave samples light/ped_btn every clock.
// Ports   : light[1:0], ped_btn (master->slave); walk, dont_walk, flash,
//           countdown[CNT_W-1:0], req_pending, conflict (slave->master).
interface ped_signal_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [1:0]       light;
    logic             ped_btn;
    logic             walk;
    logic             dont_walk;
    logic             flash;
    logic [CNT_W-1:0] countdown;
    logic             req_pending;
    logic             conflict;

    modport master (
        output light, ped_btn,
        input  walk, dont_walk, flash, countdown, req_pending, conflict
    );

    modport slave (
        input  light, ped_btn,
        output walk, dont_walk, flash, countdown, req_pending, conflict
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Purpose : pedestrian WALK / flashing DONT_WALK sequencer slaved to the vehicle light.
// Latency : walk rises one clock after a RED entry with a request pending; all outputs registered.
// Backpressure: none; inputs are sampled every clock and never stalled.
// Ports   : clk, rstb (sync, active low); sig (slave modport): light, ped_btn in;
//           walk, dont_walk, flash, countdown, req_pending, conflict out.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rstb,
    ped_signal_ctrl_if.slave  sig
);

    localparam logic [1:0]       RED        = 2'b00;
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_TOP  = CNT_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       light_q;
    logic             btn_q;

    logic btn_rise;
    logic red_entry;
    logic non_red;

    assign btn_rise  = sig.ped_btn & ~btn_q;
    // Power-up/reset treats the previous light as RED, so a steady RED after
    // reset never looks like a fresh RED phase.
    assign red_entry = (sig.light == RED) && (light_q != RED);
    // Code 11 is invalid and deliberately treated like any other non-RED code.
    assign non_red   = (sig.light != RED);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state           <= IDLE;
            cnt             <= '0;
            light_q         <= RED;
            btn_q           <= 1'b0;
            sig.walk        <= 1'b0;
            sig.dont_walk   <= 1'b1;
            sig.flash       <= 1'b0;
            sig.countdown   <= '0;
            sig.req_pending <= 1'b0;
            sig.conflict    <= 1'b0;
        end else begin
            light_q <= sig.light;
            btn_q   <= sig.ped_btn;

            case (state)
                IDLE: begin
                    // A press on the same cycle as RED entry is served directly,
                    // so req_pending never needs to be set for it.
                    if (red_entry && (sig.req_pending || btn_rise)) begin
                        state           <= WALK;
                        cnt             <= WALK_LOAD;
                        sig.walk        <= 1'b1;
                        sig.dont_walk   <= 1'b0;
                        sig.req_pending <= 1'b0;
                    end else if (btn_rise) begin
                        sig.req_pending <= 1'b1;
                    end
                end

                WALK: begin
                    // Presses while walking are dropped: the walker is already served.
                    if (non_red) begin
                        state         <= IDLE;
                        sig.conflict  <= 1'b1;
                        sig.walk      <= 1'b0;
                        sig.dont_walk <= 1'b1;
                    end else if (cnt == '0) begin
                        state         <= FLASH;
                        cnt           <= FLASH_LOAD;
                        sig.walk      <= 1'b0;
                        sig.dont_walk <= 1'b1;
                        sig.flash     <= 1'b1;
                        sig.countdown <= FLASH_TOP;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                FLASH: begin
                    // A press during clearance waits for the next RED entry.
                    if (btn_rise) begin
                        sig.req_pending <= 1'b1;
                    end
                    // Abort is checked before expiry so a late light change
                    // always raises conflict.
                    if (non_red) begin
                        state         <= IDLE;
                        sig.conflict  <= 1'b1;
                        sig.flash     <= 1'b0;
                        sig.countdown <= '0;
                    end else if (cnt == '0) begin
                        state         <= IDLE;
                        sig.flash     <= 1'b0;
                        sig.countdown <= '0;
                    end else begin
                        cnt           <= cnt - ONE;
                        // countdown shows the remaining clocks, i.e. the new cnt + 1.
                        sig.countdown <= cnt;
                    end
                end

                default: begin
                    state         <= IDLE;
                    sig.walk      <= 1'b0;
                    sig.dont_walk <= 1'b1;
                    sig.flash     <= 1'b0;
                    sig.countdown <= '0;
                end
            endcase
        end
    end

endmodule
